// File: rtl/leg_mem_pkg.sv
// Shared types and sizes for the LEGv8 data-RAM arbiter.
// No logic; no latency or backpressure of its own.
package leg_mem_pkg;

    localparam int LEG_ADDR_W = 12;
    localparam int LEG_DATA_W = 64;
    localparam int MEM_WORDS  = 4096;
    // Wide enough for the largest legal MAX_BURST (15).
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2
    } owner_e;

endpackage

// File: rtl/leg_rr_pick.sv
// Two-way round-robin grant with bounded bursts between CPU and debug ports.
// Purely combinational (0-cycle grant); a requester waits while not granted.
module leg_rr_pick
    import leg_mem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             c_req_i,
    input  logic             d_req_i,
    input  owner_e           owner_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  owner_e           last_i,
    output logic             c_gnt_o,
    output logic             d_gnt_o
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    logic burst_left;

    assign burst_left = (cnt_i < BURST_LIM);

    always_comb begin
        c_gnt_o = 1'b0;
        d_gnt_o = 1'b0;
        unique case (owner_i)
            CPU: begin
                if (c_req_i && (burst_left || !d_req_i)) begin
                    c_gnt_o = 1'b1;
                end else if (d_req_i) begin
                    d_gnt_o = 1'b1;
                end
            end
            DBG: begin
                if (d_req_i && (burst_left || !c_req_i)) begin
                    d_gnt_o = 1'b1;
                end else if (c_req_i) begin
                    c_gnt_o = 1'b1;
                end
            end
            default: begin
                // Idle bus: a tie goes to whichever port was not served last.
                if (c_req_i && d_req_i) begin
                    if (last_i == CPU) begin
                        d_gnt_o = 1'b1;
                    end else begin
                        c_gnt_o = 1'b1;
                    end
                end else begin
                    c_gnt_o = c_req_i;
                    d_gnt_o = d_req_i;
                end
            end
        endcase
    end

endmodule

// File: rtl/leg_ram_arbiter.sv
// Shares the single-port data RAM between the CPU load/store unit and the debug port.
// 0-cycle grant, 1-cycle read data; ungranted requesters hold, cpu_stall freezes the control FSM.
module leg_ram_arbiter
    import leg_mem_pkg::*;
#(
    parameter int ADDR_W    = LEG_ADDR_W,
    parameter int DATA_W    = LEG_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              cpu_stall,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    owner_e           owner_q, owner_d;
    owner_e           last_q, last_d;
    owner_e           rd_tag_q, rd_tag_d;
    owner_e           gnt_port;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] c_hold_q, d_hold_q;

    logic c_gnt_raw, d_gnt_raw;
    logic any_gnt_raw;
    logic we_raw;

    leg_rr_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .c_req_i (c_req),
        .d_req_i (d_req),
        .owner_i (owner_q),
        .cnt_i   (cnt_q),
        .last_i  (last_q),
        .c_gnt_o (c_gnt_raw),
        .d_gnt_o (d_gnt_raw)
    );

    assign any_gnt_raw = c_gnt_raw | d_gnt_raw;
    assign we_raw      = c_gnt_raw ? c_we : (d_gnt_raw ? d_we : 1'b0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= NONE;
            cnt_q    <= '0;
            last_q   <= DBG;
            rd_tag_q <= NONE;
        end else begin
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            rd_tag_q <= rd_tag_d;
        end
    end

    // Next-state
    always_comb begin
        gnt_port = NONE;
        owner_d  = NONE;
        cnt_d    = '0;
        last_d   = last_q;
        rd_tag_d = NONE;
        if (any_gnt_raw) begin
            if (c_gnt_raw) begin
                gnt_port = CPU;
            end else begin
                gnt_port = DBG;
            end
            owner_d = gnt_port;
            last_d  = gnt_port;
            // A burst that hits its limit uncontested starts a fresh count.
            if ((gnt_port == owner_q) && (cnt_q < BURST_LIM)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
            if (!we_raw) begin
                rd_tag_d = gnt_port;
            end
        end
    end

    // Outputs: grants are forced low while reset is asserted.
    always_comb begin
        c_gnt     = c_gnt_raw & rst_n;
        d_gnt     = d_gnt_raw & rst_n;
        ram_en    = c_gnt | d_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (c_gnt) begin
            ram_we    = c_we;
            ram_addr  = c_addr;
            ram_wdata = c_wdata;
        end else if (d_gnt) begin
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    assign cpu_stall = c_req & ~c_gnt;

    // Each port keeps showing its last read word between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            if (rd_tag_q == CPU) begin
                c_hold_q <= ram_rdata;
            end
            if (rd_tag_q == DBG) begin
                d_hold_q <= ram_rdata;
            end
        end
    end

    assign c_rvalid = (rd_tag_q == CPU);
    assign d_rvalid = (rd_tag_q == DBG);
    assign c_rdata  = c_rvalid ? ram_rdata : c_hold_q;
    assign d_rdata  = d_rvalid ? ram_rdata : d_hold_q;

endmodule

// File: tb/tb_leg_ram_arbiter.sv
// Directed bench for leg_ram_arbiter with a behavioural synchronous RAM.
module tb_leg_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req, c_we, d_req, d_we;
    logic [11:0] c_addr, d_addr;
    logic [63:0] c_wdata, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, cpu_stall;
    logic [63:0] c_rdata, d_rdata;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata = 64'd0;
    logic [63:0] mem [4096];

    int n_chk  = 0;
    int n_pass = 0;
    int waited;
    logic exp_c, exp_d, prev_c, prev_d;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    leg_ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .cpu_stall (cpu_stall),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'd0; c_wdata = 64'd0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'd1; d_wdata = 64'd0;

        // Reset holds everything quiet even with both ports requesting
        repeat (3) @(negedge clk);
        #1;
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_c_rdata", c_rdata, 0);

        // Continuous contention: CPU x4, DBG x4, CPU x4
        @(negedge clk);
        rst_n = 1'b1;
        prev_c = 1'b0;
        prev_d = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_c = (i < 4) || (i >= 8);
            exp_d = !exp_c;
            chk($sformatf("cont_c_gnt_%0d", i), c_gnt, exp_c);
            chk($sformatf("cont_d_gnt_%0d", i), d_gnt, exp_d);
            chk($sformatf("cont_stall_%0d", i), cpu_stall, exp_d);
            chk($sformatf("cont_c_rvalid_%0d", i), c_rvalid, prev_c);
            chk($sformatf("cont_d_rvalid_%0d", i), d_rvalid, prev_d);
            prev_c = exp_c;
            prev_d = exp_d;
            @(negedge clk);
        end
        c_req = 1'b0; d_req = 1'b0;
        #1;
        chk("idle_c_gnt", c_gnt, 0);
        chk("idle_ram_en", ram_en, 0);
        chk("idle_c_rvalid", c_rvalid, 1);

        // CPU write 0x12 to addr 5, then read it back
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b1; c_addr = 12'd5; c_wdata = 64'h12;
        #1;
        chk("cwr_gnt", c_gnt, 1);
        chk("cwr_ram_we", ram_we, 1);
        chk("cwr_ram_addr", ram_addr, 5);
        chk("cwr_ram_wdata", ram_wdata, 64'h12);
        chk("cwr_stall", cpu_stall, 0);
        @(negedge clk);
        c_we = 1'b0;
        #1;
        chk("crd_gnt", c_gnt, 1);
        chk("crd_ram_we", ram_we, 0);
        chk("crd_no_rvalid_after_write", c_rvalid, 0);
        @(negedge clk);
        c_req = 1'b0;
        #1;
        chk("crd_rvalid", c_rvalid, 1);
        chk("crd_rdata", c_rdata, 64'h12);
        chk("crd_d_rvalid", d_rvalid, 0);
        @(negedge clk);
        #1;
        chk("crd_rvalid_drop", c_rvalid, 0);
        chk("crd_rdata_hold", c_rdata, 64'h12);

        // CPU alone for 10 cycles: uninterrupted grants through the burst wrap
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            c_req = 1'b1; c_addr = 12'(i);
            #1;
            chk($sformatf("solo_c_gnt_%0d", i), c_gnt, 1);
            @(negedge clk);
        end
        // DBG joins on cycle 11; CPU burst count is at 2, so DBG waits 2 cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'd9;
        waited = 0;
        while (waited < 6) begin
            #1;
            if (d_gnt) break;
            waited++;
            @(negedge clk);
        end
        chk("dbg_wait", waited, 2);
        chk("dbg_wait_stall", cpu_stall, 1);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("switch_back_c_gnt", c_gnt, 1);
        @(negedge clk);
        c_req = 1'b0;

        // DBG write 0xAB to addr 7, CPU reads it the very next cycle
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'd7; d_wdata = 64'hAB;
        #1;
        chk("dwr_gnt", d_gnt, 1);
        chk("dwr_ram_addr", ram_addr, 7);
        chk("dwr_ram_wdata", ram_wdata, 64'hAB);
        @(negedge clk);
        d_req = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'd7;
        #1;
        chk("raw_c_gnt", c_gnt, 1);
        chk("raw_ram_addr", ram_addr, 7);
        @(negedge clk);
        c_req = 1'b0;
        #1;
        chk("raw_c_rvalid", c_rvalid, 1);
        chk("raw_c_rdata", c_rdata, 64'hAB);
        chk("raw_d_rvalid", d_rvalid, 0);

        // DBG read of addr 5 routes to the debug port only
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'd5;
        #1;
        chk("drd_gnt", d_gnt, 1);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("drd_rvalid", d_rvalid, 1);
        chk("drd_rdata", d_rdata, 64'h12);
        chk("drd_c_rvalid", c_rvalid, 0);
        chk("drd_c_rdata_hold", c_rdata, 64'hAB);

        // Reset pulsed right after an accepted CPU read drops the response
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 12'd7;
        #1;
        chk("mid_c_gnt", c_gnt, 1);
        @(posedge clk);
        #1;
        c_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_c_rvalid_now", c_rvalid, 0);
        @(negedge clk);
        #1;
        chk("mid_c_rvalid", c_rvalid, 0);
        chk("mid_c_rdata", c_rdata, 0);
        chk("mid_d_rdata", d_rdata, 0);
        chk("mid_ram_en", ram_en, 0);
        rst_n = 1'b1;
        c_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 12'd5;
        #1;
        chk("post_tie_c_gnt", c_gnt, 1);
        chk("post_tie_d_gnt", d_gnt, 0);
        @(negedge clk);
        c_req = 1'b0;
        #1;
        chk("post_d_gnt", d_gnt, 1);
        chk("post_c_rvalid", c_rvalid, 1);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("post_d_rvalid", d_rvalid, 1);
        chk("post_d_rdata", d_rdata, 64'h12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
